// File: rtl/sw_alloc_first_arbiter_pkg.sv
// Shared sizing, slice-offset helpers and the rotating priority picker for the
// input-side stage of the switch allocator.
package sw_alloc_first_arbiter_pkg;

  localparam int VC_NUM_PER_PORT = 4;
  localparam int PORT_NUM        = 5;
  localparam int ARBITER_WIDTH   = PORT_NUM - 1;
  localparam int PORT_REQ_WIDTH  = PORT_NUM * ARBITER_WIDTH;
  localparam int VC_REQ_WIDTH    = PORT_NUM * VC_NUM_PER_PORT;
  localparam int VC_IDX_W        = (VC_NUM_PER_PORT > 1) ? $clog2(VC_NUM_PER_PORT) : 1;

  typedef logic [VC_NUM_PER_PORT-1:0] vc_vec_t;
  typedef logic [ARBITER_WIDTH-1:0]   dest_t;
  typedef logic [VC_IDX_W-1:0]        vc_idx_t;

  // Offset of port p's slice within the per-port request/grant buses.
  function automatic int port_base(input int p);
    return p * ARBITER_WIDTH;
  endfunction

  // Offset of port p's VC group within the flat VC request vector.
  function automatic int vc_base(input int p);
    return p * VC_NUM_PER_PORT;
  endfunction

  // Offset of VC v of port p within the flat destination bus.
  function automatic int dest_base(input int p, input int v);
    return (p * VC_NUM_PER_PORT + v) * ARBITER_WIDTH;
  endfunction

  // First set bit of req scanning upward from ptr with wrap-around, one-hot.
  function automatic vc_vec_t rr_pick(input vc_vec_t req, input vc_idx_t ptr);
    vc_vec_t sel;
    logic    found;
    int      idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < VC_NUM_PER_PORT; k++) begin
      idx = (int'(ptr) + k) % VC_NUM_PER_PORT;
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic vc_idx_t onehot_to_idx(input vc_vec_t oh);
    vc_idx_t idx;
    idx = '0;
    for (int k = 0; k < VC_NUM_PER_PORT; k++) begin
      if (oh[k]) idx = idx | vc_idx_t'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sw_alloc_first_arbiter_if.sv
// Bundle between the VC buffers / second-stage arbiter (master) and the
// first-stage allocator (slave).
interface sw_alloc_first_arbiter_if;
  import sw_alloc_first_arbiter_pkg::*;

  logic [VC_REQ_WIDTH-1:0]               vc_requests;
  logic [VC_REQ_WIDTH*ARBITER_WIDTH-1:0] vc_dest_port;
  logic [PORT_REQ_WIDTH-1:0]             port_requests;
  logic [PORT_REQ_WIDTH-1:0]             port_granted;
  logic [VC_REQ_WIDTH-1:0]               vc_granted;
  logic [PORT_REQ_WIDTH-1:0]             granted_dest;
  logic [PORT_NUM-1:0]                   any_vc_granted;
  logic                                  grant_err;

  modport master (
    output vc_requests, vc_dest_port, port_granted,
    input  port_requests, vc_granted, granted_dest, any_vc_granted, grant_err
  );

  modport slave (
    input  vc_requests, vc_dest_port, port_granted,
    output port_requests, vc_granted, granted_dest, any_vc_granted, grant_err
  );
endinterface

// File: rtl/sw_alloc_first_arbiter_vc_rr_arbiter.sv
// Per-port round-robin VC picker; the pointer moves past the selected VC only
// when the downstream stage accepts the request built from that selection.
module vc_rr_arbiter
  import sw_alloc_first_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  vc_vec_t i_req,
  input  logic    i_accept,
  output vc_vec_t o_sel,
  output logic    o_any
);

  vc_idx_t r_ptr;
  vc_idx_t w_sel_idx;

  always_comb begin
    o_sel     = rr_pick(i_req, r_ptr);
    o_any     = |i_req;
    w_sel_idx = onehot_to_idx(o_sel);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      if (w_sel_idx == vc_idx_t'(VC_NUM_PER_PORT - 1)) r_ptr <= '0;
      else                                             r_ptr <= w_sel_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sw_alloc_first_arbiter.sv
// First (input-side) stage of the two-stage switch allocator: per-port VC pick,
// destination request, grant matching, registered VC grants and crossbar selects.
module sw_alloc_first_arbiter
  import sw_alloc_first_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  sw_alloc_first_arbiter_if.slave bus
);

  vc_vec_t                   w_sel      [PORT_NUM];
  dest_t                     w_req_dest [PORT_NUM];
  logic [PORT_NUM-1:0]       w_any;
  logic [PORT_NUM-1:0]       w_accept;
  logic [PORT_NUM-1:0]       w_spurious;
  logic [PORT_REQ_WIDTH-1:0] w_port_requests;

  vc_vec_t                   r_vc_grant [PORT_NUM];
  dest_t                     r_dest     [PORT_NUM];
  logic [PORT_NUM-1:0]       r_any;
  logic                      r_grant_err;

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    vc_rr_arbiter u_arb (
      .clk      (clk),
      .rst_n    (reset),
      .i_req    (bus.vc_requests[p*VC_NUM_PER_PORT +: VC_NUM_PER_PORT]),
      .i_accept (w_accept[p]),
      .o_sel    (w_sel[p]),
      .o_any    (w_any[p])
    );
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    w_port_requests = '0;
    w_accept        = '0;
    w_spurious      = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      w_req_dest[p] = '0;
      if (w_any[p]) begin
        for (int v = 0; v < VC_NUM_PER_PORT; v++) begin
          if (w_sel[p][v]) w_req_dest[p] = bus.vc_dest_port[dest_base(p, v) +: ARBITER_WIDTH];
        end
      end
      w_port_requests[port_base(p) +: ARBITER_WIDTH] = w_req_dest[p];
      // A grant counts only where it overlaps this cycle's request; any other bit is a protocol error.
      w_accept[p]   = |(bus.port_granted[port_base(p) +: ARBITER_WIDTH] & w_req_dest[p]);
      w_spurious[p] = |(bus.port_granted[port_base(p) +: ARBITER_WIDTH] & ~w_req_dest[p]);
    end
  end

  // NOTE: only the control registers are reset; there is no storage array here
  // that would need to stay unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        r_vc_grant[p] <= '0;
        r_dest[p]     <= '0;
      end
      r_any       <= '0;
      r_grant_err <= 1'b0;
    end else begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if (w_accept[p]) begin
          r_vc_grant[p] <= w_sel[p];
          r_dest[p]     <= w_req_dest[p];
          r_any[p]      <= 1'b1;
        end else begin
          r_vc_grant[p] <= '0;
          r_dest[p]     <= '0;
          r_any[p]      <= 1'b0;
        end
      end
      r_grant_err <= r_grant_err | (|w_spurious);
    end
  end

  always_comb begin
    bus.port_requests  = w_port_requests;
    bus.vc_granted     = '0;
    bus.granted_dest   = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      bus.vc_granted[vc_base(p) +: VC_NUM_PER_PORT] = r_vc_grant[p];
      bus.granted_dest[port_base(p) +: ARBITER_WIDTH] = r_dest[p];
    end
    bus.any_vc_granted = r_any;
    bus.grant_err      = r_grant_err;
  end

endmodule

// File: tb/tb_sw_alloc_first_arbiter.sv
// Directed bench for the first-stage switch allocator with hand-computed expectations.
module tb_sw_alloc_first_arbiter;
  import sw_alloc_first_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  sw_alloc_first_arbiter_if bus ();

  sw_alloc_first_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dest(input int p, input int v, input logic [3:0] d);
    bus.vc_dest_port[(p*VC_NUM_PER_PORT + v)*ARBITER_WIDTH +: ARBITER_WIDTH] = d;
  endtask

  task automatic clear_inputs();
    bus.vc_requests  = '0;
    bus.vc_dest_port = '0;
    bus.port_granted = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    clear_inputs();
    tick();
    tick();

    // Reset state
    check("rst_vc_granted",   32'(bus.vc_granted),     32'h0);
    check("rst_granted_dest", 32'(bus.granted_dest),   32'h0);
    check("rst_any",          32'(bus.any_vc_granted), 32'h0);
    check("rst_err",          32'(bus.grant_err),      32'h0);
    reset = 1'b1;
    tick();

    // Port 2: VC0 and VC3 requesting, pointer at VC0 -> VC0 destination
    bus.vc_requests[8]  = 1'b1;
    bus.vc_requests[11] = 1'b1;
    set_dest(2, 0, 4'b0001);
    set_dest(2, 3, 4'b1000);
    #1;
    check("p2_first_sel", 32'(bus.port_requests[11:8]), 32'h1);
    clear_inputs();

    // Port 0 VC2 -> dest 0010, granted next cycle
    bus.vc_requests[2] = 1'b1;
    set_dest(0, 2, 4'b0010);
    #1;
    check("p0_req_comb", 32'(bus.port_requests), 32'h00002);
    bus.port_granted[1] = 1'b1;
    tick();
    check("p0_vc_granted",   32'(bus.vc_granted),     32'h00004);
    check("p0_granted_dest", 32'(bus.granted_dest),   32'h00002);
    check("p0_any",          32'(bus.any_vc_granted), 32'h01);
    check("p0_err_clean",    32'(bus.grant_err),      32'h0);
    clear_inputs();
    tick();
    check("p0_grant_drops", 32'(bus.vc_granted), 32'h0);

    // Port 1: VC0,VC1 requesting, no grant for 3 cycles, then grant
    bus.vc_requests[4] = 1'b1;
    bus.vc_requests[5] = 1'b1;
    set_dest(1, 0, 4'b0001);
    set_dest(1, 1, 4'b0010);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("p1_hold_req",   32'(bus.port_requests[7:4]), 32'h1);
      check("p1_hold_nogrt", 32'(bus.vc_granted[7:4]),    32'h0);
    end
    bus.port_granted[7:4] = 4'b0001;
    tick();
    bus.port_granted = '0;
    check("p1_late_grant", 32'(bus.vc_granted[7:4]),    32'h1);
    check("p1_next_sel",   32'(bus.port_requests[7:4]), 32'h2);
    clear_inputs();

    // Port 3: move pointer to VC1, then a spurious grant must not move it
    bus.vc_requests[12] = 1'b1;
    set_dest(3, 0, 4'b0001);
    #1;
    bus.port_granted[15:12] = 4'b0001;
    tick();
    check("p3_legit_grant", 32'(bus.vc_granted[15:12]), 32'h1);
    clear_inputs();
    bus.port_granted[12] = 1'b1;
    tick();
    check("p3_spur_vc",  32'(bus.vc_granted[15:12]), 32'h0);
    check("p3_spur_any", 32'(bus.any_vc_granted[3]), 32'h0);
    check("p3_spur_err", 32'(bus.grant_err),         32'h1);
    bus.port_granted = '0;
    bus.vc_requests[12] = 1'b1;
    bus.vc_requests[13] = 1'b1;
    set_dest(3, 0, 4'b0001);
    set_dest(3, 1, 4'b0010);
    tick();
    tick();
    check("p3_ptr_kept",  32'(bus.port_requests[15:12]), 32'h2);
    check("p3_err_stick", 32'(bus.grant_err),             32'h1);
    clear_inputs();

    do_reset();
    check("err_cleared", 32'(bus.grant_err), 32'h0);

    // Port 1: all VCs requesting, granted every cycle -> strict round-robin
    bus.vc_requests[7:4] = 4'b1111;
    set_dest(1, 0, 4'b0001);
    set_dest(1, 1, 4'b0010);
    set_dest(1, 2, 4'b0100);
    set_dest(1, 3, 4'b1000);
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_oh;
      exp_oh = 4'b0001 << (k % 4);
      #1;
      check("rr_req", 32'(bus.port_requests[7:4]), 32'(exp_oh));
      bus.port_granted[7:4] = exp_oh;
      tick();
      check("rr_vc_granted", 32'(bus.vc_granted[7:4]),   32'(exp_oh));
      check("rr_dest",       32'(bus.granted_dest[7:4]), 32'(exp_oh));
    end

    // Pointer now at VC1: grant VC1, then reset mid-cycle
    #1;
    bus.port_granted[7:4] = 4'b0010;
    tick();
    check("mid_vc1", 32'(bus.vc_granted[7:4]), 32'h2);
    bus.port_granted = '0;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_vc",   32'(bus.vc_granted),     32'h0);
    check("mid_rst_dest", 32'(bus.granted_dest),   32'h0);
    check("mid_rst_any",  32'(bus.any_vc_granted), 32'h0);
    tick();
    reset = 1'b1;
    #1;
    check("post_rst_req", 32'(bus.port_requests[7:4]), 32'h1);
    bus.port_granted[7:4] = 4'b0001;
    tick();
    check("post_rst_vc0", 32'(bus.vc_granted[7:4]), 32'h1);
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sw_alloc_first_arbiter.md
Name: sw_alloc_first_arbiter

Overview:
Input-side (requester) stage of the two-stage switch allocator. Each input port picks one requesting VC using a round-robin pointer and presents that VC's destination as a one-hot request to the output-side second arbiter. It then consumes the returned grants and issues registered VC grants and crossbar selects. Pointers advance only on an accepted grant (iSLIP-style), which keeps both stages consistent and starvation-free.

Parameters:
VC_NUM_PER_PORT, 4, VCs per input port
PORT_NUM, 5, router ports
ARBITER_WIDTH, PORT_NUM-1, compressed destination width; a port never requests itself
PORT_REQ_WIDTH, PORT_NUM*ARBITER_WIDTH, width of the request and grant buses to and from the second arbiter
VC_REQ_WIDTH, PORT_NUM*VC_NUM_PER_PORT, total VC count

Ports:
clk  input  1  single clock
reset  input  1  asynchronous, active-low
vc_requests  input  VC_REQ_WIDTH  bit i*VC_NUM_PER_PORT+v = VC v of port i holds a flit and has downstream credit
vc_dest_port  input  VC_REQ_WIDTH*ARBITER_WIDTH  per-VC one-hot compressed destination; slice (i*VC_NUM_PER_PORT+v)*ARBITER_WIDTH
port_requests  output  PORT_REQ_WIDTH  slice i*ARBITER_WIDTH = port i request to second arbiter; combinational
port_granted  input  PORT_REQ_WIDTH  same slicing and encoding as port_requests
vc_granted  output  VC_REQ_WIDTH  registered one-hot-per-port VC grant (flit read enable)
granted_dest  output  PORT_REQ_WIDTH  registered compressed destination of the granted flit, per input port (crossbar select)
any_vc_granted  output  PORT_NUM  registered OR of vc_granted per port
grant_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (reset=0, async): vc_granted, granted_dest, any_vc_granted and grant_err = 0; every port pointer = VC0.
- Per port i, combinational:
  - sel_i = first requesting VC scanning from ptr_i upward, wrapping.
  - port_requests slice = vc_dest_port of sel_i if any VC is requesting, else 0.
  - If the destination slice is not one-hot, it is forwarded as-is; validity is the producer's responsibility.
- Grant accept for port i: (port_granted slice & port_requests slice) != 0.
- On a clk edge with accept:
  - vc_granted slice <= onehot(sel_i).
  - granted_dest slice <= port_requests slice.
  - any_vc_granted[i] <= 1.
  - ptr_i <= sel_i+1 mod VC_NUM_PER_PORT; VC3 wraps to VC0.
- Without accept: that port's registered outputs go to 0 next cycle and ptr_i is unchanged.
- Latency: port_granted to vc_granted is 1 cycle; request path is 0 cycles.
- A port may be granted on consecutive cycles; the pointer rotates each cycle, so all-VCs-requesting gives strict round-robin.
- Spurious grant: any port_granted bit not matched by port_requests.
  - The bit is ignored; no VC grant and no pointer move result from it.
  - grant_err <= 1 and stays 1 until reset.
- If requests change in the same cycle a grant returns, the grant is judged against the current-cycle port_requests.
- Reset mid-operation clears all state immediately; the first post-reset selection starts from VC0.
- Ports are fully independent; the stage itself has no cross-port interaction.

Decomposition:
- Shared package: ARBITER_WIDTH and PORT_REQ_WIDTH derivations; slice-index helper functions for port/VC/destination offsets; rotate-and-priority-encode function.
- Sub-module vc_rr_arbiter, instantiated once per input port:
  - holds ptr_i;
  - inputs: VC request vector and external accept;
  - outputs: one-hot sel and any-request;
  - the pointer updates only on accept.
- The top level does the destination muxing, grant matching, output registers and the error flag.

Test Plan:
1. Reset low for 2 cycles -> all outputs 0; after release, port 2 with VC0 and VC3 requesting selects VC0.
2. Port 0 VC2 requests with dest 4'b0010 -> port_requests[3:0]=0010 the same cycle; drive port_granted[1]=1 -> next cycle vc_granted[2]=1, granted_dest[3:0]=0010, any_vc_granted[0]=1.
3. Port 1 with all 4 VCs requesting and granted every cycle -> vc_granted[7:4] sequence 0001, 0010, 0100, 1000, 0001 (wrap).
4. Port 1 VC0 and VC1 requesting, no grant for 3 cycles -> port_requests holds VC0's dest, vc_granted[7:4]=0; grant on cycle 4 -> VC0 granted, next selection VC1.
5. port_granted[12]=1 (port 3) with vc_requests for port 3 = 0 -> no VC grant, port 3 pointer unchanged, grant_err=1 and held until reset.
6. Reset pulsed low mid-stream during case 3 after VC1 is granted -> outputs 0 immediately; after release, the next grant goes to VC0.
